spi_acc_responder: RTL and testbench
====================================

Name: spi_acc_responder

Overview:
- SPI slave that answers the ADXL362-style register protocol used by the accelerometer readout path.
- Lets the on-board SPI master be run against a synthesizable accelerometer stand-in: on the bench, or looped back on the FPGA with the X/Y/Z values supplied from fabric.
- Decodes read (0x0B) and write (0x0A) frames on a 4-wire SPI bus, mode 0, MSB first.
- Holds a small register map: IDs, status, 12-bit X/Y/Z sample registers, and 16 scratch bytes.

Parameters:
- DEVID, 8'hAD, value returned at address 0x00
- PARTID, 8'hF2, value returned at address 0x02
- SYNC_STAGES, 2, synchronizer depth on SCK/CS/MOSI (minimum 2)
- SCRATCH_BASE, 8'h20, first address of the writable scratch block
- SCRATCH_DEPTH, 16, number of scratch bytes

Ports:
- clk  in  1  system clock; must be at least 8x the SCK frequency
- I_rst_n  in  1  reset, asynchronous, active-low
- I_spi_sck  in  1  SPI clock from master; idles low
- I_spi_cs  in  1  SPI chip select from master, active-low
- I_spi_mosi  in  1  master-out data
- O_spi_miso  out  1  slave-out data
- I_x_data  in  12  X sample, two's complement
- I_y_data  in  12  Y sample, two's complement
- I_z_data  in  12  Z sample, two's complement
- I_sample_valid  in  1  one-cycle strobe that loads X/Y/Z
- O_wr_valid  out  1  one-cycle pulse on each accepted scratch write
- O_wr_addr  out  8  address of that write
- O_wr_data  out  8  data of that write
- O_busy  out  1  high while a frame is active

Behaviour:
- Reset values: O_spi_miso=0, O_wr_valid=0, O_wr_addr=0, O_wr_data=0, O_busy=0. Sample registers, scratch and STATUS are all 0.
- SCK, CS and MOSI pass through SYNC_STAGES flops. SCK rise/fall and CS fall/rise are detected in the clk domain.
- MOSI is sampled on the detected SCK rise.
- MISO is updated on the detected SCK fall. It is registered and changes within SYNC_STAGES+1 clk of the pin edge.
- FSM states:
  - IDLE: waits for CS fall.
  - CMD: bits 0-7.
  - ADDR: bits 8-15.
  - DATA_RD / DATA_WR: each subsequent 8-bit byte.
  - SKIP: unknown command; remaining bits ignored, MISO=0.
- Every state goes to IDLE on CS rise.
- Command byte: 0x0B goes to DATA_RD, 0x0A goes to DATA_WR, any other value goes to SKIP.
- Read path:
  - On the SCK fall following the 16th rise, the byte at reg[addr] is loaded into the TX shift register and bit7 is driven.
  - Each following fall shifts out the next bit.
  - After each full byte, addr is incremented and the next byte is loaded on the next fall (burst read).
- Write path:
  - Each completed byte is written to reg[addr] only if SCRATCH_BASE <= addr < SCRATCH_BASE+SCRATCH_DEPTH.
  - An accepted write pulses O_wr_valid for one clk with its addr/data. Out-of-range writes are dropped silently with no pulse.
  - addr then increments.
- Address increment is 8-bit and wraps 0xFF to 0x00.
- Register map (read):
  - 0x00 DEVID; 0x01 8'h1D; 0x02 PARTID.
  - 0x08 X[11:4]; 0x09 Y[11:4]; 0x0A Z[11:4].
  - 0x0B STATUS, bit0 = DATA_READY, other bits 0.
  - 0x0E X[7:0]; 0x0F {4{X[11]}},X[11:8}; 0x10/0x11 the same layout for Y; 0x12/0x13 the same layout for Z.
  - Scratch block; all other addresses read 0x00.
- Sample update:
  - If I_sample_valid is seen while CS is high, X/Y/Z load on the next clk and DATA_READY is set.
  - If it is seen while a frame is active, the values are captured into a pending buffer and applied on the clk after CS rise. This prevents L/H tearing. The last strobe in a frame wins.
- DATA_READY is cleared at the CS rise of any read frame that shifted out at least one full byte from 0x0E–0x13.
- If a pending apply and a DATA_READY clear happen at the same CS rise, the apply wins: DATA_READY stays 1.
- CS rise mid-byte: the partial byte is discarded, no write occurs, MISO returns to 0 and the FSM goes to IDLE.
- SCK edges while CS is high are ignored.
- O_busy = CS low and the frame is armed. MISO is 0 whenever not in DATA_RD.
- Reset asserted mid-frame: everything returns to reset values. If CS is still low when reset releases, the frame is unarmed and ignored until CS goes high and falls again.

Decomposition:
- Package spi_acc_pkg holds:
  - Command constants CMD_WRITE=8'h0A and CMD_READ=8'h0B.
  - Register address constants (DEVID, PARTID, XDATA8..ZDATA_H, STATUS).
  - FSM state encoding.
- Sub-module spi_slave_sync: synchronizer plus edge detect. It outputs sck_rise, sck_fall, cs_fall, cs_rise, cs_n_s and mosi_s.

Test Plan:
- Frame 0x0B,0x00 then one read byte -> MISO byte 0xAD; O_wr_valid never asserts.
- Sample X=12'hF3C with CS high, then 0x0B,0x0E plus 2 bytes -> 0x3C, 0xFF. STATUS reads 1 before this frame and 0 after it.
- Write 0x0A,0x20,0x55,0xAA -> two O_wr_valid pulses (0x20/0x55, 0x21/0xAA). A following burst read 0x0B,0x20 returns 0x55, 0xAA.
- I_sample_valid Y=12'h123 mid-frame while reading 0x10/0x11 -> the frame returns the old values (0x00, 0x00). The next frame returns 0x23, 0x01.
- Write 0x0A,0x20 then CS rises after 5 data bits -> no O_wr_valid; reading 0x20 returns its prior value.
- Command 0x3C followed by 16 bits -> MISO stays 0 and no writes occur; the next 0x0B,0x02 returns 0xF2.

Source files
------------

// File: rtl/spi_acc_pkg.sv
//==============================================================================
// spi_acc_pkg : commands, register map and FSM encoding for spi_acc_responder
// Rev 1.0
//==============================================================================
`default_nettype none

package spi_acc_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;

  localparam logic [7:0] ADDR_DEVID     = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_XDATA8    = 8'h08;
  localparam logic [7:0] ADDR_YDATA8    = 8'h09;
  localparam logic [7:0] ADDR_ZDATA8    = 8'h0A;
  localparam logic [7:0] ADDR_STATUS    = 8'h0B;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;

  localparam logic [7:0] DEVID_MST_VAL  = 8'h1D;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DATA_WR = 3'd4,
    ST_SKIP    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spi_slave_sync.sv
//==============================================================================
// spi_slave_sync : SCK/CS/MOSI synchronizer with clk-domain edge detection
// Rev 1.0
//==============================================================================
`default_nettype none

module spi_slave_sync
  import spi_acc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_spi_sck,
  input  logic i_spi_cs,
  input  logic i_spi_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_fall,
  output logic o_cs_rise,
  output logic o_cs_n_s,
  output logic o_mosi_s
);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_cs_d;

  // CS resets low: a frame already running at reset release never shows a fall.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
      r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  assign o_sck_rise = r_sck_sync[SYNC_STAGES-1] & ~r_sck_d;
  assign o_sck_fall = ~r_sck_sync[SYNC_STAGES-1] & r_sck_d;
  assign o_cs_fall  = ~r_cs_sync[SYNC_STAGES-1] & r_cs_d;
  assign o_cs_rise  = r_cs_sync[SYNC_STAGES-1] & ~r_cs_d;
  assign o_cs_n_s   = r_cs_sync[SYNC_STAGES-1];
  assign o_mosi_s   = r_mosi_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_acc_responder.sv
//==============================================================================
// spi_acc_responder : ADXL362-style SPI register responder (accelerometer stand-in)
// Rev 1.0
//==============================================================================
`default_nettype none

module spi_acc_responder
  import spi_acc_pkg::*;
#(
  parameter logic [7:0] DEVID         = 8'hAD,
  parameter logic [7:0] PARTID        = 8'hF2,
  parameter int         SYNC_STAGES   = 2,
  parameter logic [7:0] SCRATCH_BASE  = 8'h20,
  parameter int         SCRATCH_DEPTH = 16
) (
  input  logic        clk,
  input  logic        I_rst_n,
  input  logic        I_spi_sck,
  input  logic        I_spi_cs,
  input  logic        I_spi_mosi,
  output logic        O_spi_miso,
  input  logic [11:0] I_x_data,
  input  logic [11:0] I_y_data,
  input  logic [11:0] I_z_data,
  input  logic        I_sample_valid,
  output logic        O_wr_valid,
  output logic [7:0]  O_wr_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_busy
);

  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise, w_cs_n_s, w_mosi_s;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .i_rst_n    (I_rst_n),
    .i_spi_sck  (I_spi_sck),
    .i_spi_cs   (I_spi_cs),
    .i_spi_mosi (I_spi_mosi),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_fall  (w_cs_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_n_s   (w_cs_n_s),
    .o_mosi_s   (w_mosi_s)
  );

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_rx_sh;
  logic [7:0]  r_tx_sh;
  logic [7:0]  r_addr;
  logic        r_miso, r_rd_clr;
  logic        r_wr_valid;
  logic [7:0]  r_wr_addr, r_wr_data;
  logic [7:0]  r_scratch [SCRATCH_DEPTH];
  logic [11:0] r_x, r_y, r_z, r_px, r_py, r_pz;
  logic        r_pend_valid, r_apply, r_data_ready;

  logic        w_active, w_in_frame, w_byte_done, w_scr_hit;
  logic [7:0]  w_rx_byte, w_rd_data;

  assign w_active    = (r_state != ST_IDLE);
  assign w_in_frame  = w_active & ~w_cs_rise;
  assign w_rx_byte   = {r_rx_sh, w_mosi_s};
  assign w_byte_done = w_sck_rise & (r_bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_cs_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_cs_fall) w_state_nxt = ST_CMD;
        ST_CMD:     if (w_byte_done)
                      w_state_nxt = (w_rx_byte == CMD_READ || w_rx_byte == CMD_WRITE) ? ST_ADDR : ST_SKIP;
        ST_ADDR:    if (w_byte_done)
                      w_state_nxt = r_tx_sh[0] ? ST_DATA_RD : ST_DATA_WR;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    w_scr_hit = 1'b0;
    case (r_addr)
      ADDR_DEVID:     w_rd_data = DEVID;
      ADDR_DEVID_MST: w_rd_data = DEVID_MST_VAL;
      ADDR_PARTID:    w_rd_data = PARTID;
      ADDR_XDATA8:    w_rd_data = r_x[11:4];
      ADDR_YDATA8:    w_rd_data = r_y[11:4];
      ADDR_ZDATA8:    w_rd_data = r_z[11:4];
      ADDR_STATUS:    w_rd_data = {7'd0, r_data_ready};
      ADDR_XDATA_L:   w_rd_data = r_x[7:0];
      ADDR_XDATA_H:   w_rd_data = {{4{r_x[11]}}, r_x[11:8]};
      ADDR_YDATA_L:   w_rd_data = r_y[7:0];
      ADDR_YDATA_H:   w_rd_data = {{4{r_y[11]}}, r_y[11:8]};
      ADDR_ZDATA_L:   w_rd_data = r_z[7:0];
      ADDR_ZDATA_H:   w_rd_data = {{4{r_z[11]}}, r_z[11:8]};
      default:        w_rd_data = 8'h00;
    endcase
    for (int i = 0; i < SCRATCH_DEPTH; i++) begin
      if (r_addr == SCRATCH_BASE + 8'(i)) begin
        w_rd_data = r_scratch[i];
        w_scr_hit = 1'b1;
      end
    end
  end

  // r_tx_sh[0] doubles as the read/write flag while the address byte is in flight.
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_bit_cnt  <= 3'd0;
      r_rx_sh    <= 7'd0;
      r_tx_sh    <= 8'd0;
      r_addr     <= 8'd0;
      r_miso     <= 1'b0;
      r_rd_clr   <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'd0;
      r_wr_data  <= 8'd0;
      for (int i = 0; i < SCRATCH_DEPTH; i++) r_scratch[i] <= 8'd0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_cs_rise) begin
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
        r_rd_clr  <= 1'b0;
      end else if (!w_active) begin
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_rx_sh   <= w_rx_byte[6:0];
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (w_byte_done) begin
          case (r_state)
            ST_CMD:  r_tx_sh <= {7'd0, (w_rx_byte == CMD_READ)};
            ST_ADDR: r_addr  <= w_rx_byte;
            ST_DATA_WR: begin
              if (w_scr_hit) begin
                for (int i = 0; i < SCRATCH_DEPTH; i++)
                  if (r_addr == SCRATCH_BASE + 8'(i)) r_scratch[i] <= w_rx_byte;
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_addr;
                r_wr_data  <= w_rx_byte;
              end
              r_addr <= r_addr + 8'd1;
            end
            ST_DATA_RD: begin
              if (r_addr >= ADDR_XDATA_L && r_addr <= ADDR_ZDATA_H) r_rd_clr <= 1'b1;
              r_addr <= r_addr + 8'd1;
            end
            default: ;
          endcase
        end
        if (w_sck_fall && r_state == ST_DATA_RD) begin
          if (r_bit_cnt == 3'd0) begin
            r_miso  <= w_rd_data[7];
            r_tx_sh <= {w_rd_data[6:0], 1'b0};
          end else begin
            r_miso  <= r_tx_sh[7];
            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

  // Strobes inside a frame are parked and applied the clk after CS rise; apply beats clear.
  always_ff @(posedge clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_x <= 12'd0; r_y <= 12'd0; r_z <= 12'd0;
      r_px <= 12'd0; r_py <= 12'd0; r_pz <= 12'd0;
      r_pend_valid <= 1'b0;
      r_apply      <= 1'b0;
      r_data_ready <= 1'b0;
    end else begin
      r_apply <= 1'b0;
      if (w_cs_rise) begin
        r_apply      <= r_pend_valid;
        r_pend_valid <= 1'b0;
        if (r_rd_clr) r_data_ready <= 1'b0;
      end
      if (r_apply) begin
        r_x <= r_px; r_y <= r_py; r_z <= r_pz;
        r_data_ready <= 1'b1;
      end
      if (I_sample_valid) begin
        if (w_in_frame) begin
          r_px <= I_x_data; r_py <= I_y_data; r_pz <= I_z_data;
          r_pend_valid <= 1'b1;
        end else begin
          r_x <= I_x_data; r_y <= I_y_data; r_z <= I_z_data;
          r_data_ready <= 1'b1;
        end
      end
    end
  end

  assign O_spi_miso = r_miso;
  assign O_wr_valid = r_wr_valid;
  assign O_wr_addr  = r_wr_addr;
  assign O_wr_data  = r_wr_data;
  assign O_busy     = ~w_cs_n_s & w_active;

endmodule

`default_nettype wire

// File: tb/tb_spi_acc_responder.sv
//==============================================================================
// tb_spi_acc_responder : directed self-checking bench for spi_acc_responder
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_spi_acc_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck, cs, mosi;
  logic        miso;
  logic [11:0] xd, yd, zd;
  logic        sv;
  logic        wr_valid;
  logic [7:0]  wr_addr, wr_data;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  int         wr_cnt  = 0;
  int         miso_hi = 0;
  logic [7:0] wr_a_log [0:31];
  logic [7:0] wr_d_log [0:31];

  always #5 clk = ~clk;

  spi_acc_responder dut (
    .clk            (clk),
    .I_rst_n        (rst_n),
    .I_spi_sck      (sck),
    .I_spi_cs       (cs),
    .I_spi_mosi     (mosi),
    .O_spi_miso     (miso),
    .I_x_data       (xd),
    .I_y_data       (yd),
    .I_z_data       (zd),
    .I_sample_valid (sv),
    .O_wr_valid     (wr_valid),
    .O_wr_addr      (wr_addr),
    .O_wr_data      (wr_data),
    .O_busy         (busy)
  );

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_a_log[wr_cnt % 32] <= wr_addr;
      wr_d_log[wr_cnt % 32] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (miso) miso_hi <= miso_hi + 1;
  end

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      rx[i] = miso;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic xbits(input logic [7:0] tx, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic cs_begin();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_end();
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (3 * HALF) @(negedge clk);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] dummy;
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(a, dummy);
    xfer(8'h00, d);
    cs_end();
  endtask

  task automatic pulse_sample(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    xd = x; yd = y; zd = z;
    sv = 1'b1;
    @(negedge clk);
    sv = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; sv = 1'b0;
    xd = 12'd0; yd = 12'd0; zd = 12'd0;
    repeat (4) @(negedge clk);
    n_chk++; if (miso !== 1'b0)     begin n_fail++; $display("FAIL reset_miso got=%b exp=0", miso); end
    n_chk++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    n_chk++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    n_chk++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    n_chk++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_devid();
    logic [7:0] d0, d1, dummy;
    int w0;
    w0 = wr_cnt;
    cs_begin();
    xfer(8'h0B, dummy);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_in_frame got=%b exp=1", busy); end
    xfer(8'h00, dummy);
    xfer(8'h00, d0);
    xfer(8'h00, d1);
    cs_end();
    n_chk++; if (d0 !== 8'hAD) begin n_fail++; $display("FAIL devid got=%h exp=AD", d0); end
    n_chk++; if (d1 !== 8'h1D) begin n_fail++; $display("FAIL devid_mst got=%h exp=1D", d1); end
    n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL devid_no_write got=%0d exp=0", wr_cnt - w0); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_frame got=%b exp=0", busy); end
    n_chk++; if (miso !== 1'b0) begin n_fail++; $display("FAIL miso_after_frame got=%b exp=0", miso); end
  endtask

  task automatic test_sample_idle();
    logic [7:0] st, lo, hi, dummy;
    read_reg(8'h0B, st);
    n_chk++; if (st !== 8'h00) begin n_fail++; $display("FAIL status_initial got=%h exp=00", st); end
    pulse_sample(12'hF3C, 12'h000, 12'h000);
    read_reg(8'h0B, st);
    n_chk++; if (st !== 8'h01) begin n_fail++; $display("FAIL status_ready got=%h exp=01", st); end
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(8'h0E, dummy);
    xfer(8'h00, lo);
    xfer(8'h00, hi);
    cs_end();
    n_chk++; if (lo !== 8'h3C) begin n_fail++; $display("FAIL xdata_l got=%h exp=3C", lo); end
    n_chk++; if (hi !== 8'hFF) begin n_fail++; $display("FAIL xdata_h got=%h exp=FF", hi); end
    read_reg(8'h0B, st);
    n_chk++; if (st !== 8'h00) begin n_fail++; $display("FAIL status_cleared got=%h exp=00", st); end
    read_reg(8'h08, st);
    n_chk++; if (st !== 8'hF3) begin n_fail++; $display("FAIL xdata8 got=%h exp=F3", st); end
  endtask

  task automatic test_write_burst();
    logic [7:0] d0, d1, dummy;
    int w0;
    w0 = wr_cnt;
    cs_begin();
    xfer(8'h0A, dummy);
    xfer(8'h20, dummy);
    xfer(8'h55, dummy);
    xfer(8'hAA, dummy);
    cs_end();
    n_chk++; if (wr_cnt - w0 != 2) begin n_fail++; $display("FAIL wr_pulse_count got=%0d exp=2", wr_cnt - w0); end
    n_chk++; if (wr_a_log[w0 % 32] !== 8'h20 || wr_d_log[w0 % 32] !== 8'h55) begin
      n_fail++; $display("FAIL wr_first got=%h/%h exp=20/55", wr_a_log[w0 % 32], wr_d_log[w0 % 32]); end
    n_chk++; if (wr_a_log[(w0 + 1) % 32] !== 8'h21 || wr_d_log[(w0 + 1) % 32] !== 8'hAA) begin
      n_fail++; $display("FAIL wr_second got=%h/%h exp=21/AA", wr_a_log[(w0 + 1) % 32], wr_d_log[(w0 + 1) % 32]); end
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(8'h20, dummy);
    xfer(8'h00, d0);
    xfer(8'h00, d1);
    cs_end();
    n_chk++; if (d0 !== 8'h55) begin n_fail++; $display("FAIL burst_rd0 got=%h exp=55", d0); end
    n_chk++; if (d1 !== 8'hAA) begin n_fail++; $display("FAIL burst_rd1 got=%h exp=AA", d1); end
  endtask

  task automatic test_midframe_sample();
    logic [7:0] lo, hi, st, dummy;
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(8'h10, dummy);
    pulse_sample(12'hF3C, 12'h123, 12'h000);
    xfer(8'h00, lo);
    xfer(8'h00, hi);
    cs_end();
    n_chk++; if (lo !== 8'h00 || hi !== 8'h00) begin n_fail++; $display("FAIL midframe_old got=%h %h exp=00 00", lo, hi); end
    read_reg(8'h0B, st);
    n_chk++; if (st !== 8'h01) begin n_fail++; $display("FAIL apply_beats_clear got=%h exp=01", st); end
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(8'h10, dummy);
    xfer(8'h00, lo);
    xfer(8'h00, hi);
    cs_end();
    n_chk++; if (lo !== 8'h23 || hi !== 8'h01) begin n_fail++; $display("FAIL midframe_new got=%h %h exp=23 01", lo, hi); end
    read_reg(8'h0B, st);
    n_chk++; if (st !== 8'h00) begin n_fail++; $display("FAIL status_after_y got=%h exp=00", st); end
  endtask

  task automatic test_abort();
    logic [7:0] d, dummy;
    int w0;
    w0 = wr_cnt;
    cs_begin();
    xfer(8'h0A, dummy);
    xfer(8'h20, dummy);
    xbits(8'hF0, 5);
    cs_end();
    n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL abort_no_write got=%0d exp=0", wr_cnt - w0); end
    n_chk++; if (busy !== 1'b0 || miso !== 1'b0) begin n_fail++; $display("FAIL abort_idle got=busy%b miso%b exp=0 0", busy, miso); end
    read_reg(8'h20, d);
    n_chk++; if (d !== 8'h55) begin n_fail++; $display("FAIL abort_keep got=%h exp=55", d); end
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] d, dummy;
    int w0, m0;
    w0 = wr_cnt;
    m0 = miso_hi;
    cs_begin();
    xfer(8'h3C, dummy);
    xfer(8'h20, dummy);
    xfer(8'hFF, dummy);
    cs_end();
    n_chk++; if (miso_hi != m0) begin n_fail++; $display("FAIL skip_miso got=%0d high cycles exp=0", miso_hi - m0); end
    n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL skip_no_write got=%0d exp=0", wr_cnt - w0); end
    read_reg(8'h02, d);
    n_chk++; if (d !== 8'hF2) begin n_fail++; $display("FAIL partid got=%h exp=F2", d); end
  endtask

  task automatic test_range_and_wrap();
    logic [7:0] d0, d1, dummy;
    int w0;
    w0 = wr_cnt;
    cs_begin();
    xfer(8'h0A, dummy);
    xfer(8'h2F, dummy);
    xfer(8'h11, dummy);
    xfer(8'h22, dummy);
    cs_end();
    n_chk++; if (wr_cnt - w0 != 1) begin n_fail++; $display("FAIL range_count got=%0d exp=1", wr_cnt - w0); end
    n_chk++; if (wr_a_log[w0 % 32] !== 8'h2F || wr_d_log[w0 % 32] !== 8'h11) begin
      n_fail++; $display("FAIL range_last got=%h/%h exp=2F/11", wr_a_log[w0 % 32], wr_d_log[w0 % 32]); end
    read_reg(8'h30, d0);
    n_chk++; if (d0 !== 8'h00) begin n_fail++; $display("FAIL range_drop got=%h exp=00", d0); end
    cs_begin();
    xfer(8'h0B, dummy);
    xfer(8'hFF, dummy);
    xfer(8'h00, d0);
    xfer(8'h00, d1);
    cs_end();
    n_chk++; if (d0 !== 8'h00 || d1 !== 8'hAD) begin n_fail++; $display("FAIL addr_wrap got=%h %h exp=00 AD", d0, d1); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d, dummy;
    int w0;
    cs_begin();
    xfer(8'h0A, dummy);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (busy !== 1'b0 || miso !== 1'b0) begin n_fail++; $display("FAIL rst_mid got=busy%b miso%b exp=0 0", busy, miso); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    w0 = wr_cnt;
    xfer(8'h0A, dummy);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL unarmed_busy got=%b exp=0", busy); end
    xfer(8'h20, dummy);
    xfer(8'h77, dummy);
    cs_end();
    n_chk++; if (wr_cnt != w0) begin n_fail++; $display("FAIL unarmed_write got=%0d exp=0", wr_cnt - w0); end
    read_reg(8'h20, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL scratch_reset got=%h exp=00", d); end
    read_reg(8'h0B, d);
    n_chk++; if (d !== 8'h00) begin n_fail++; $display("FAIL status_reset got=%h exp=00", d); end
  endtask

  initial begin
    test_reset();
    test_devid();
    test_sample_idle();
    test_write_burst();
    test_midframe_sample();
    test_abort();
    test_unknown_cmd();
    test_range_and_wrap();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
